buffer_serializer: RTL and testbench

Downstream drain stage for the team's word FIFO (`buffer`). It watches the FIFO fill level and pulls one word at a time when the FIFO is non-empty. Each word is shifted out on a single-wire, UART-style serial line: one start bit, data LSB first, an optional even-parity bit, and one stop bit. It sits between the FIFO head port and the board-level TX pin.

---
 rtl/buffer_serializer_pkg.sv | 20 ++
 rtl/buffer_serializer_if.sv | 23 ++
 rtl/buffer_serializer_bit_timer.sv | 40 ++++
 rtl/buffer_serializer.sv | 145 ++++++++++++++
 tb/tb_buffer_serializer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_serializer_pkg.sv
// Shared definitions for the FIFO drain serializer: state encoding and frame helpers.
// Even parity is computed on a zero-extended word so one helper serves every data width.
package buffer_serializer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int frame_cycles(input int data_width, input int parity_en,
                                      input int clks_per_bit);
    return (data_width + 2 + parity_en) * clks_per_bit;
  endfunction

  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/buffer_serializer_if.sv
// FIFO head-port bundle between the word FIFO (master) and the serializer (slave).
interface buffer_serializer_if #(
  parameter int DATA_WIDTH  = 15,
  parameter int LEVEL_WIDTH = 4
);

  logic [DATA_WIDTH-1:0]  head;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   pull;

  modport master (
    output head,
    output level,
    input  pull
  );

  modport slave (
    input  head,
    input  level,
    output pull
  );

endinterface

// File: rtl/buffer_serializer_bit_timer.sv
// Bit-period tick counter: bit_done pulses on the last clock of every serial bit.
// Holding clear parks the counter at zero so each bit period starts aligned to state entry.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);

  logic [TICK_W-1:0] tick_r;
  logic              done_s;

  // Tick combinational decode of the terminal count.
  always_comb begin
    if (!clear && (tick_r == LAST_TICK)) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Tick counter, wrapping explicitly so non-power-of-two periods are exact.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_r <= {TICK_W{1'b0}};
    end else if (clear || done_s) begin
      tick_r <= {TICK_W{1'b0}};
    end else begin
      tick_r <= tick_r + TICK_W'(1);
    end
  end

  assign bit_done = done_s;

endmodule

// File: rtl/buffer_serializer.sv
// Drains the word FIFO one word at a time onto a UART-style line:
// start bit, data LSB first, optional even parity, stop bit.
module buffer_serializer
  import buffer_serializer_pkg::*;
#(
  parameter int DATA_WIDTH   = 15,
  parameter int LEVEL_WIDTH  = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  buffer_serializer_if.slave  fifo,
  output logic                tx,
  output logic                busy,
  output logic [15:0]         frames_sent
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  logic [2:0]            state_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] shift_next_s;
  logic                  parity_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic                  tx_r;
  logic                  busy_r;
  logic [15:0]           frames_r;
  logic                  pull_s;
  logic                  timer_clear_s;
  logic                  bit_done_s;

  // Pop strobe: only from IDLE, so it can be high for at most one cycle per frame.
  always_comb begin
    if ((state_r == ST_IDLE) && enable && (fifo.level != {LEVEL_WIDTH{1'b0}}) && !reset) begin
      pull_s = 1'b1;
    end else begin
      pull_s = 1'b0;
    end
  end

  // Timer is parked while idle so the start bit gets a full period from the pull edge.
  always_comb begin
    if (state_r == ST_IDLE) begin
      timer_clear_s = 1'b1;
    end else begin
      timer_clear_s = 1'b0;
    end
  end

  assign shift_next_s = shift_r >> 1;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear_s),
    .bit_done (bit_done_s)
  );

  // Frame FSM; tx is loaded with the value of the next bit so it changes on bit boundaries.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= {DATA_WIDTH{1'b0}};
      parity_r  <= 1'b0;
      bit_cnt_r <= {BIT_W{1'b0}};
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      frames_r  <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= {BIT_W{1'b0}};
          if (pull_s) begin
            shift_r  <= fifo.head;
            parity_r <= even_parity(64'(fifo.head));
            state_r  <= ST_START;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done_s) begin
            state_r   <= ST_DATA;
            tx_r      <= shift_r[0];
            bit_cnt_r <= {BIT_W{1'b0}};
          end
        end
        ST_DATA: begin
          if (bit_done_s) begin
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= {BIT_W{1'b0}};
              if (PARITY_EN != 0) begin
                state_r <= ST_PARITY;
                tx_r    <= parity_r;
              end else begin
                state_r <= ST_STOP;
                tx_r    <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
              shift_r   <= shift_next_s;
              tx_r      <= shift_next_s[0];
            end
          end
        end
        ST_PARITY: begin
          if (bit_done_s) begin
            state_r   <= ST_STOP;
            tx_r      <= 1'b1;
            bit_cnt_r <= {BIT_W{1'b0}};
          end
        end
        ST_STOP: begin
          if (bit_done_s) begin
            state_r   <= ST_IDLE;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            frames_r  <= frames_r + 16'd1;
            bit_cnt_r <= {BIT_W{1'b0}};
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          tx_r      <= 1'b1;
          busy_r    <= 1'b0;
          bit_cnt_r <= {BIT_W{1'b0}};
        end
      endcase
    end
  end

  assign fifo.pull   = pull_s;
  assign tx          = tx_r;
  assign busy        = busy_r;
  assign frames_sent = frames_r;

endmodule

// File: tb/tb_buffer_serializer.sv
// Bench for buffer_serializer: a frame-level model predicts pull/tx/busy/frames_sent every
// cycle for two instances (no parity, even parity), plus literal checks of the scenarios.
module tb_buffer_serializer;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en      [2];
  logic        tx_w    [2];
  logic        busy_w  [2];
  logic [15:0] fs_w    [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  bit          m_in     [2];
  int          m_k      [2];
  logic [7:0]  m_word   [2];
  logic [15:0] m_frames [2];
  bit          exp_pull [2];
  int          frame_len[2];

  logic txlog0 [$];
  logic txlog1 [$];
  int   busy_cnt [2];
  int   pull_cnt [2];
  int   pull_at0 [$];

  buffer_serializer_if #(.DATA_WIDTH(DW), .LEVEL_WIDTH(4)) if0 ();
  buffer_serializer_if #(.DATA_WIDTH(DW), .LEVEL_WIDTH(4)) if1 ();

  buffer_serializer #(
    .DATA_WIDTH(DW), .LEVEL_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(0)
  ) u_dut0 (
    .clock(clock), .reset(reset), .enable(en[0]), .fifo(if0),
    .tx(tx_w[0]), .busy(busy_w[0]), .frames_sent(fs_w[0])
  );

  buffer_serializer #(
    .DATA_WIDTH(DW), .LEVEL_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1)
  ) u_dut1 (
    .clock(clock), .reset(reset), .enable(en[1]), .fifo(if1),
    .tx(tx_w[1]), .busy(busy_w[1]), .frames_sent(fs_w[1])
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line value the frame rules demand at frame cycle m_k of lane l.
  function automatic logic model_tx(input int l);
    int j;
    if (!m_in[l]) return 1'b1;
    j = m_k[l] / CPB;
    if (j == 0) return 1'b0;
    if (j <= DW) return m_word[l][j-1];
    if ((l == 1) && (j == DW + 1)) return ^m_word[l];
    return 1'b1;
  endfunction

  task automatic sync_fifo();
    if0.level = 4'(q0.size());
    if1.level = 4'(q1.size());
    if (q0.size() != 0) if0.head = q0[0]; else if0.head = 8'h00;
    if (q1.size() != 0) if1.head = q1[0]; else if1.head = 8'h00;
  endtask

  task automatic clear_logs();
    txlog0.delete();
    txlog1.delete();
    pull_at0.delete();
    for (int l = 0; l < 2; l++) begin
      busy_cnt[l] = 0;
      pull_cnt[l] = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    for (int l = 0; l < 2; l++) begin
      int   lvl;
      logic pl;
      lvl = (l == 0) ? q0.size() : q1.size();
      pl  = (l == 0) ? if0.pull : if1.pull;
      exp_pull[l] = !reset && !m_in[l] && en[l] && (lvl != 0);
      chk($sformatf("pull%0d", l), 32'(pl), 32'(exp_pull[l]));
      chk($sformatf("busy%0d", l), 32'(busy_w[l]), 32'(m_in[l]));
      chk($sformatf("tx%0d", l), 32'(tx_w[l]), 32'(model_tx(l)));
      chk($sformatf("frames%0d", l), 32'(fs_w[l]), 32'(m_frames[l]));
      if (pl) begin
        pull_cnt[l]++;
        if (l == 0) pull_at0.push_back(cyc);
      end
      if (busy_w[l]) busy_cnt[l]++;
      if (l == 0) txlog0.push_back(tx_w[0]); else txlog1.push_back(tx_w[1]);
    end
    @(posedge clock);
    #1;
    for (int l = 0; l < 2; l++) begin
      if (reset) begin
        m_in[l]     = 1'b0;
        m_k[l]      = 0;
        m_frames[l] = 16'd0;
      end else if (exp_pull[l]) begin
        m_in[l] = 1'b1;
        m_k[l]  = 0;
        if (l == 0) begin
          m_word[0] = q0[0];
          void'(q0.pop_front());
        end else begin
          m_word[1] = q1[0];
          void'(q1.pop_front());
        end
      end else if (m_in[l]) begin
        m_k[l]++;
        if (m_k[l] == frame_len[l]) begin
          m_in[l]     = 1'b0;
          m_frames[l] = m_frames[l] + 16'd1;
        end
      end
    end
    cyc++;
    sync_fifo();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Samples each bit mid-period; log entry 0 is the pull cycle, bit j starts at entry 1+4j.
  task automatic check_bits(input int l, input int nbits, input logic [10:0] exp, input string name);
    logic [10:0] v;
    v = 11'd0;
    for (int j = 0; j < nbits; j++) begin
      if (l == 0) v[j] = txlog0[3 + CPB*j]; else v[j] = txlog1[3 + CPB*j];
    end
    chk(name, 32'(v), 32'(exp));
  endtask

  initial begin
    frame_len[0] = 40;
    frame_len[1] = 44;
    for (int l = 0; l < 2; l++) begin
      en[l] = 1'b0; m_in[l] = 1'b0; m_k[l] = 0; m_word[l] = 8'h00; m_frames[l] = 16'd0;
      exp_pull[l] = 1'b0;
    end
    clear_logs();
    sync_fifo();
    @(posedge clock);
    #1;

    // Idle with an empty FIFO.
    run(2);
    reset = 1'b0;
    en[0] = 1'b1;
    run(50);
    chk("idle_pulls", 32'(pull_cnt[0]), 32'd0);
    chk("idle_frames", 32'(fs_w[0]), 32'd0);
    chk("idle_tx", 32'(tx_w[0]), 32'd1);

    // Reset on frame cycle 10 of an 8'hFF frame.
    clear_logs();
    q0.push_back(8'hFF);
    sync_fifo();
    run(11);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    chk("rst_tx", 32'(tx_w[0]), 32'd1);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_frames", 32'(fs_w[0]), 32'd0);

    // Held reset with a word waiting must not pull; the frame starts on release.
    q0.push_back(8'hA5);
    sync_fifo();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    clear_logs();
    run(45);
    chk("a5_pulls", 32'(pull_cnt[0]), 32'd1);
    chk("a5_busy", 32'(busy_cnt[0]), 32'd40);
    check_bits(0, 10, 11'h34A, "a5_bits");
    chk("a5_frames", 32'(fs_w[0]), 32'd1);

    // Three words back to back.
    clear_logs();
    q0.push_back(8'h01);
    q0.push_back(8'h02);
    q0.push_back(8'h03);
    sync_fifo();
    run(127);
    chk("b2b_pulls", 32'(pull_cnt[0]), 32'd3);
    if (pull_at0.size() == 3) begin
      chk("b2b_gap1", 32'(pull_at0[1] - pull_at0[0]), 32'd41);
      chk("b2b_gap2", 32'(pull_at0[2] - pull_at0[1]), 32'd41);
    end else begin
      chk("b2b_pull_log", 32'(pull_at0.size()), 32'd3);
    end
    chk("b2b_frames", 32'(fs_w[0]), 32'd4);

    // Enable dropped on frame cycle 5 with a second word waiting.
    clear_logs();
    q0.push_back(8'h11);
    q0.push_back(8'h22);
    sync_fifo();
    run(6);
    en[0] = 1'b0;
    run(50);
    chk("en_pulls", 32'(pull_cnt[0]), 32'd1);
    chk("en_frames", 32'(fs_w[0]), 32'd5);
    chk("en_tx", 32'(tx_w[0]), 32'd1);
    en[0] = 1'b1;
    run(42);
    chk("en_pulls2", 32'(pull_cnt[0]), 32'd2);
    chk("en_frames2", 32'(fs_w[0]), 32'd6);

    // Even parity instance, word 8'h07.
    clear_logs();
    q1.push_back(8'h07);
    sync_fifo();
    en[1] = 1'b1;
    run(46);
    chk("par_busy", 32'(busy_cnt[1]), 32'd44);
    chk("par_bit", 32'(txlog1[3 + CPB*9]), 32'd1);
    check_bits(1, 11, 11'h60E, "par_bits");
    chk("par_frames", 32'(fs_w[1]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
